// File: rtl/fetch_queue_if.sv
// Fetch-stage port bundle: instruction memory read port, decode valid/ready
// handshake, and the redirect/halt controls coming back from later stages.
interface fetch_queue_if #(
   parameter int ADDR_W = 8
);
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              halt_req;
   logic              halted;
   logic              mem_busy;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              inst_valid;
   logic              inst_ready;
   logic [31:0]       inst;
   logic [31:0]       inst_pc;
   logic [31:0]       inst_pc4;

   // master: the fetch queue itself
   modport master (
      input  redirect_valid, redirect_pc, halt_req, mem_busy, imem_rdata, inst_ready,
      output halted, imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4
   );

   // slave: memory, decode and branch-resolution side
   modport slave (
      output redirect_valid, redirect_pc, halt_req, mem_busy, imem_rdata, inst_ready,
      input  halted, imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage with a DEPTH-entry prefetch FIFO, redirect flush and halt.
// Define FETCH_BYPASS_EN to present a response straight to decode when the FIFO is empty.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic           clk,
   input logic           rst,
   fetch_queue_if.master bus
);
   localparam int          PTR_W = $clog2(DEPTH);
   localparam int          CNT_W = $clog2(DEPTH + 1);
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef enum logic {RUN, HALTED} state_t;

   state_t           state;
   logic             halted_r;
   logic [31:0]      fetch_pc;
   logic             inflight;
   logic [31:0]      inflight_pc;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   logic [31:0]      pc_mem   [DEPTH];
   logic [31:0]      word_mem [DEPTH];

   logic [CNT_W-1:0] occupancy;
   logic             fetch_go;
   logic             resp_keep;
   logic             fifo_valid;
   logic             bypass;
   logic             out_valid;
   logic             pop;
   logic             pop_fifo;
   logic             push;
   logic [31:0]      head_word;
   logic [31:0]      head_pc;
   logic [31:0]      out_word;
   logic [31:0]      out_pc;
   logic             unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

   // Buffered plus outstanding words; never issue a read that could overflow the FIFO.
   assign occupancy = count + CNT_W'(inflight);
   assign fetch_go  = (state == RUN) && !rst && !bus.mem_busy && !bus.redirect_valid
                      && !bus.halt_req && (occupancy < CNT_W'(DEPTH));

   // A response is dropped when a redirect or reset lands in the cycle it returns.
   assign resp_keep  = inflight && !rst && !bus.redirect_valid;
   assign fifo_valid = (count != '0);
   assign head_word  = word_mem[rd_ptr];
   assign head_pc    = pc_mem[rd_ptr];

`ifdef FETCH_BYPASS_EN
   // An empty FIFO hands the returning word straight to decode; it is only
   // written into the FIFO if decode does not take it this cycle.
   assign bypass   = resp_keep && !fifo_valid;
   assign out_word = fifo_valid ? head_word : bus.imem_rdata;
   assign out_pc   = fifo_valid ? head_pc   : inflight_pc;
`else
   assign bypass   = 1'b0;
   assign out_word = head_word;
   assign out_pc   = head_pc;
`endif

   assign out_valid = !rst && !bus.redirect_valid && (fifo_valid || bypass);
   assign pop       = out_valid && bus.inst_ready;
   assign pop_fifo  = pop && fifo_valid;
   assign push      = resp_keep && !(bypass && bus.inst_ready);

   always_comb begin
      // NOTE: default first, so no branch can leave count_next unassigned and infer a latch.
      count_next = count;
      if (push && !pop_fifo) begin
         count_next = count + CNT_W'(1);
      end else if (pop_fifo && !push) begin
         count_next = count - CNT_W'(1);
      end
   end

   // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         halted_r    <= 1'b0;
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= RESET_PC;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else if (bus.redirect_valid) begin
         state    <= RUN;
         halted_r <= 1'b0;
         fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
         inflight <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         if (bus.halt_req) begin
            state    <= HALTED;
            halted_r <= 1'b1;
         end
         if (fetch_go) begin
            fetch_pc    <= fetch_pc + 32'd4;
            inflight_pc <= fetch_pc;
         end
         inflight <= fetch_go;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_fifo) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_next;
      end
   end

   // NOTE: storage is not reset; count and the pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= inflight_pc;
         word_mem[wr_ptr] <= bus.imem_rdata;
      end
   end

   assign bus.imem_req   = fetch_go;
   assign bus.imem_addr  = fetch_pc[ADDR_W-1:0];
   assign bus.inst_valid = out_valid;
   assign bus.inst       = out_valid ? out_word : NOP;
   assign bus.inst_pc    = out_pc;
   assign bus.inst_pc4   = out_pc + 32'd4;
   assign bus.halted     = halted_r;

endmodule
